// File: rtl/bus_pkg.sv
// Shared bus encoding for the processor datapath: opcodes, sequencer states,
// one-hot bus select constants and the control-word bundle.
package bus_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StT1   = 2'd1,
    StT2   = 2'd2,
    StT3   = 2'd3
  } state_e;

  localparam logic [10:0] SEL_NONE = 11'b000_0000_0000;
  localparam logic [10:0] SEL_R7   = 11'b100_0000_0000;
  localparam logic [10:0] SEL_R6   = 11'b010_0000_0000;
  localparam logic [10:0] SEL_R5   = 11'b001_0000_0000;
  localparam logic [10:0] SEL_R4   = 11'b000_1000_0000;
  localparam logic [10:0] SEL_R3   = 11'b000_0100_0000;
  localparam logic [10:0] SEL_R2   = 11'b000_0010_0000;
  localparam logic [10:0] SEL_R1   = 11'b000_0001_0000;
  localparam logic [10:0] SEL_R0   = 11'b000_0000_1000;
  localparam logic [10:0] SEL_DIN  = 11'b000_0000_0100;
  localparam logic [10:0] SEL_G    = 11'b000_0000_0010;
  localparam logic [10:0] SEL_MEM  = 11'b000_0000_0001;

  typedef struct packed {
    logic [10:0] bus_sel;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic        addsub;
    logic        addr_in;
    logic        dout_in;
    logic        w_d;
    logic        done;
  } ctrl_t;

  // Register one-hot (R7..R0) placed onto the register field of bus_sel.
  function automatic logic [10:0] reg_sel(input logic [7:0] onehot);
    return {onehot, 3'b000};
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-bit binary to one-hot-8 decoder used for the Rx and Ry instruction fields.
module dec3to8 (
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/bus_sequencer.sv
// Shared-bus control sequencer: latches a 9-bit instruction and steps it through T1..T3.
// Build option BUS_SEQ_MVNZ_EN enables opcode 110 as mvnz; otherwise it decodes as nop.
module bus_sequencer
  import bus_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] din,
  input  logic        g_nz,
  output logic [10:0] bus_sel,
  output logic [7:0]  r_in,
  output logic        a_in,
  output logic        g_in,
  output logic        addsub,
  output logic        addr_in,
  output logic        dout_in,
  output logic        w_d,
  output logic        done
);

  state_e     state_q;
  logic [8:0] ir_q;
  logic [2:0] opcode;
  logic [7:0] rx_oh;
  logic [7:0] ry_oh;
  ctrl_t      ctrl;

  assign opcode = ir_q[8:6];

  dec3to8 u_dec_rx (
    .sel    (ir_q[5:3]),
    .onehot (rx_oh)
  );

  dec3to8 u_dec_ry (
    .sel    (ir_q[2:0]),
    .onehot (ry_oh)
  );

  // The step that raises done always returns to IDLE; T3 is terminal for every opcode.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) begin
            ir_q    <= din[8:0];
            state_q <= StT1;
          end
        end
        StT1:    state_q <= ctrl.done ? StIdle : StT2;
        StT2:    state_q <= ctrl.done ? StIdle : StT3;
        StT3:    state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      StIdle: ;
      StT1: begin
        unique case (opcode)
          OP_MV: begin
            ctrl.bus_sel = reg_sel(ry_oh);
            ctrl.r_in    = rx_oh;
            ctrl.done    = 1'b1;
          end
          OP_MVI: begin
            ctrl.bus_sel = SEL_DIN;
            ctrl.r_in    = rx_oh;
            ctrl.done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.bus_sel = reg_sel(rx_oh);
            ctrl.a_in    = 1'b1;
          end
          OP_LD, OP_ST: begin
            ctrl.bus_sel = reg_sel(ry_oh);
            ctrl.addr_in = 1'b1;
          end
`ifdef BUS_SEQ_MVNZ_EN
          OP_MVNZ: begin
            ctrl.bus_sel = reg_sel(ry_oh);
            ctrl.r_in    = g_nz ? rx_oh : 8'h00;
            ctrl.done    = 1'b1;
          end
`endif
          default: ctrl.done = 1'b1;
        endcase
      end
      StT2: begin
        unique case (opcode)
          OP_ADD, OP_SUB: begin
            ctrl.bus_sel = reg_sel(ry_oh);
            ctrl.g_in    = 1'b1;
            ctrl.addsub  = opcode[0];
          end
          OP_ST: begin
            ctrl.bus_sel = reg_sel(rx_oh);
            ctrl.dout_in = 1'b1;
          end
          // ld waits here for the memory read; nothing else reaches T2.
          default: ;
        endcase
      end
      StT3: begin
        unique case (opcode)
          OP_ADD, OP_SUB: begin
            ctrl.bus_sel = SEL_G;
            ctrl.r_in    = rx_oh;
            ctrl.done    = 1'b1;
          end
          OP_LD: begin
            ctrl.bus_sel = SEL_MEM;
            ctrl.r_in    = rx_oh;
            ctrl.done    = 1'b1;
          end
          OP_ST: begin
            ctrl.w_d     = 1'b1;
            ctrl.done    = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus_sel = ctrl.bus_sel;
  assign r_in    = ctrl.r_in;
  assign a_in    = ctrl.a_in;
  assign g_in    = ctrl.g_in;
  assign addsub  = ctrl.addsub;
  assign addr_in = ctrl.addr_in;
  assign dout_in = ctrl.dout_in;
  assign w_d     = ctrl.w_d;
  assign done    = ctrl.done;

  // Upper instruction bits carry the immediate only; g_nz matters only with mvnz built in.
`ifdef BUS_SEQ_MVNZ_EN
  logic unused_in;
  assign unused_in = ^din[15:9];
`else
  logic unused_in;
  assign unused_in = ^{din[15:9], g_nz};
`endif

endmodule

// File: tb/tb_bus_sequencer.sv
// Table-driven bench for bus_sequencer with a queue scoreboard of expected control words.
module tb_bus_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] din;
  logic        g_nz;
  logic [10:0] bus_sel;
  logic [7:0]  r_in;
  logic        a_in, g_in, addsub, addr_in, dout_in, w_d, done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  bus_sequencer dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .din     (din),
    .g_nz    (g_nz),
    .bus_sel (bus_sel),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .addsub  (addsub),
    .addr_in (addr_in),
    .dout_in (dout_in),
    .w_d     (w_d),
    .done    (done)
  );

  always #5 clock = ~clock;

  localparam logic [10:0] S0   = 11'h000;
  localparam logic [10:0] SR0  = 11'h008;
  localparam logic [10:0] SR1  = 11'h010;
  localparam logic [10:0] SR2  = 11'h020;
  localparam logic [10:0] SR3  = 11'h040;
  localparam logic [10:0] SR4  = 11'h080;
  localparam logic [10:0] SR5  = 11'h100;
  localparam logic [10:0] SR6  = 11'h200;
  localparam logic [10:0] SR7  = 11'h400;
  localparam logic [10:0] SDIN = 11'h004;
  localparam logic [10:0] SG   = 11'h002;
  localparam logic [10:0] SMEM = 11'h001;

  // Flag order: a_in, g_in, addsub, addr_in, dout_in, w_d, done
  localparam logic [6:0] F0    = 7'b0000000;
  localparam logic [6:0] FA    = 7'b1000000;
  localparam logic [6:0] FG    = 7'b0100000;
  localparam logic [6:0] FAS   = 7'b0010000;
  localparam logic [6:0] FADDR = 7'b0001000;
  localparam logic [6:0] FDOUT = 7'b0000100;
  localparam logic [6:0] FW    = 7'b0000010;
  localparam logic [6:0] FD    = 7'b0000001;

`ifdef BUS_SEQ_MVNZ_EN
  localparam logic [10:0] MVNZ_SEL  = 11'h040;
  localparam logic [7:0]  MVNZ_RIN1 = 8'h04;
`else
  localparam logic [10:0] MVNZ_SEL  = 11'h000;
  localparam logic [7:0]  MVNZ_RIN1 = 8'h00;
`endif

  typedef struct {
    logic        rst;
    logic        run;
    logic [15:0] din;
    logic        gnz;
    logic [25:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [25:0] sb[$];

  function automatic vec_t mk(input logic rst, input logic rn, input logic [15:0] d,
                              input logic gnz, input logic [10:0] sel, input logic [7:0] rin,
                              input logic [6:0] f);
    vec_t v;
    v.rst = rst;
    v.run = rn;
    v.din = d;
    v.gnz = gnz;
    v.exp = {sel, rin, f};
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    logic [25:0] got;
    logic [25:0] want;
    reset = v.rst;
    run   = v.run;
    din   = v.din;
    g_nz  = v.gnz;
    sb.push_back(v.exp);
    @(negedge clock);
    got  = {bus_sel, r_in, a_in, g_in, addsub, addr_in, dout_in, w_d, done};
    want = sb.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got sel=%h r_in=%h flags=%b, want sel=%h r_in=%h flags=%b",
               tag, got[25:15], got[14:7], got[6:0], want[25:15], want[14:7], want[6:0]);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    din   = '0;
    g_nz  = 1'b0;
    @(posedge clock);
    #1;

    // second reset cycle, then idle
    tbl.push_back(mk(1, 0, 16'h0000, 0, S0, 8'h00, F0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 16'h0000, 0, S0, 8'h00, F0));
    // mv R3,R5
    tbl.push_back(mk(0, 1, 16'o035, 0, S0, 8'h00, F0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, SR5, 8'h08, FD));
    tbl.push_back(mk(0, 0, 16'h0000, 0, S0, 8'h00, F0));
    // mvi R1,#0x00AB
    tbl.push_back(mk(0, 1, 16'o110, 0, S0, 8'h00, F0));
    tbl.push_back(mk(0, 0, 16'h00AB, 0, SDIN, 8'h02, FD));
    // sub R2,R4 with run held high mid-instruction (must be ignored)
    tbl.push_back(mk(0, 1, 16'o324, 0, S0, 8'h00, F0));
    tbl.push_back(mk(0, 1, 16'o000, 0, SR2, 8'h00, FA));
    tbl.push_back(mk(0, 1, 16'o077, 0, SR4, 8'h00, FG | FAS));
    tbl.push_back(mk(0, 0, 16'h0000, 0, SG, 8'h04, FD));
    // ld R0,[R6] issued the cycle after done
    tbl.push_back(mk(0, 1, 16'o406, 0, S0, 8'h00, F0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, SR6, 8'h00, FADDR));
    tbl.push_back(mk(0, 0, 16'h0000, 0, S0, 8'h00, F0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, SMEM, 8'h01, FD));
    // st R0,[R7]
    tbl.push_back(mk(0, 1, 16'o507, 0, S0, 8'h00, F0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, SR7, 8'h00, FADDR));
    tbl.push_back(mk(0, 0, 16'h0000, 0, SR0, 8'h00, FDOUT));
    tbl.push_back(mk(0, 0, 16'h0000, 0, S0, 8'h00, FW | FD));
    // mvnz R2,R3 with g_nz=0 then g_nz=1
    tbl.push_back(mk(0, 1, 16'o623, 1, S0, 8'h00, F0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, MVNZ_SEL, 8'h00, FD));
    tbl.push_back(mk(0, 1, 16'o623, 0, S0, 8'h00, F0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, MVNZ_SEL, MVNZ_RIN1, FD));
    // nop
    tbl.push_back(mk(0, 1, 16'o700, 0, S0, 8'h00, F0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, S0, 8'h00, FD));
    // add R1,R1
    tbl.push_back(mk(0, 1, 16'o211, 0, S0, 8'h00, F0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, SR1, 8'h00, FA));
    tbl.push_back(mk(0, 0, 16'h0000, 0, SR1, 8'h00, FG));
    tbl.push_back(mk(0, 0, 16'h0000, 0, SG, 8'h02, FD));
    tbl.push_back(mk(0, 0, 16'h0000, 0, S0, 8'h00, F0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // add R4,R5 aborted by reset in T2: no done, IDLE with zero outputs after
    apply(mk(0, 1, 16'o245, 0, S0, 8'h00, F0), "abort_idle");
    apply(mk(0, 0, 16'h0000, 0, SR4, 8'h00, FA), "abort_t1");
    apply(mk(1, 0, 16'h0000, 0, SR5, 8'h00, FG), "abort_t2_reset");
    apply(mk(0, 0, 16'h0000, 0, S0, 8'h00, F0), "abort_after");
    apply(mk(0, 0, 16'h0000, 0, S0, 8'h00, F0), "abort_after2");

    // reset while run is high must not capture an instruction
    apply(mk(1, 1, 16'o035, 0, S0, 8'h00, F0), "rst_run");
    apply(mk(0, 0, 16'h0000, 0, S0, 8'h00, F0), "rst_run_after");

    // back-to-back mv at the minimum 2-cycle issue interval
    apply(mk(0, 1, 16'o017, 0, S0, 8'h00, F0), "b2b_a_idle");
    apply(mk(0, 0, 16'h0000, 0, SR7, 8'h02, FD), "b2b_a_t1");
    apply(mk(0, 1, 16'o070, 0, S0, 8'h00, F0), "b2b_b_idle");
    apply(mk(0, 0, 16'h0000, 0, SR0, 8'h80, FD), "b2b_b_t1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
